// File: rtl/tile_scheduler.sv
// tile_scheduler: walks one GEMM job as (m outer, n middle, k inner) tile commands
// to the systolic core, one tile in flight at a time.
module tile_scheduler #(
    parameter int DIM_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_pulse,
    input  logic             abort_pulse,
    input  logic             irq_en,
    input  logic [DIM_W-1:0] cfg_M,
    input  logic [DIM_W-1:0] cfg_N,
    input  logic [DIM_W-1:0] cfg_K,
    input  logic [DIM_W-1:0] cfg_Tm,
    input  logic [DIM_W-1:0] cfg_Tn,
    input  logic [DIM_W-1:0] cfg_Tk,
    output logic             tile_valid,
    input  logic             tile_ready,
    output logic [DIM_W-1:0] tile_m,
    output logic [DIM_W-1:0] tile_n,
    output logic [DIM_W-1:0] tile_k,
    output logic [DIM_W-1:0] tile_sm,
    output logic [DIM_W-1:0] tile_sn,
    output logic [DIM_W-1:0] tile_sk,
    output logic             tile_first_k,
    output logic             tile_last_k,
    input  logic             core_tile_done,
    output logic             busy,
    output logic             done_tile_pulse,
    output logic             done_all_pulse,
    output logic             irq,
    output logic             cfg_err_pulse,
    output logic             bank_sel_rd,
    output logic [31:0]      tiles_issued
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state, state_nx;
    logic [DIM_W-1:0] dm, dn, dk, tm, tn, tk;
    logic [DIM_W:0] m_end, n_end, k_end;
    logic m_wrap, n_wrap, k_wrap, cfg_bad, dim_zero, go, adv;

    // one extra bit so base + T cannot wrap near 2^DIM_W
    assign m_end = {1'b0, tile_m} + {1'b0, tm};
    assign n_end = {1'b0, tile_n} + {1'b0, tn};
    assign k_end = {1'b0, tile_k} + {1'b0, tk};
    assign m_wrap = m_end >= {1'b0, dm};
    assign n_wrap = n_end >= {1'b0, dn};
    assign k_wrap = k_end >= {1'b0, dk};
    assign cfg_bad = cfg_Tm == '0 || cfg_Tn == '0 || cfg_Tk == '0;
    assign dim_zero = cfg_M == '0 || cfg_N == '0 || cfg_K == '0;
    assign go = state == IDLE && start_pulse && !abort_pulse;
    assign adv = state == WAIT && core_tile_done && !abort_pulse;

    assign tile_valid = state == ISSUE;
    assign busy = state != IDLE;
    assign done_all_pulse = state == DONE;
    assign irq = done_all_pulse && irq_en;
    assign tile_sm = tm < dm - tile_m ? tm : dm - tile_m;
    assign tile_sn = tn < dn - tile_n ? tn : dn - tile_n;
    assign tile_sk = tk < dk - tile_k ? tk : dk - tile_k;
    assign tile_first_k = busy && tile_k == '0;
    assign tile_last_k = busy && k_wrap;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (abort_pulse) state_nx = IDLE;
        else if (go && !cfg_bad) state_nx = dim_zero ? DONE : ISSUE;
        else if (state == ISSUE && tile_ready) state_nx = WAIT;
        else if (state == WAIT && core_tile_done) state_nx = k_wrap && n_wrap && m_wrap ? DONE : ISSUE;
        else if (state == DONE) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {dm, dn, dk, tm, tn, tk} <= '0;
            {tile_m, tile_n, tile_k} <= '0;
            tiles_issued <= '0;
            bank_sel_rd <= 1'b0;
            done_tile_pulse <= 1'b0;
            cfg_err_pulse <= 1'b0;
        end else begin
            cfg_err_pulse <= go && cfg_bad;
            done_tile_pulse <= adv && k_wrap;
            if (go && !cfg_bad) begin
                {dm, dn, dk, tm, tn, tk} <= {cfg_M, cfg_N, cfg_K, cfg_Tm, cfg_Tn, cfg_Tk};
                {tile_m, tile_n, tile_k} <= '0;
                tiles_issued <= '0;
                bank_sel_rd <= 1'b0;
            end
            if (state == ISSUE && tile_ready && !abort_pulse) tiles_issued <= tiles_issued + 32'd1;
            if (adv) begin
                bank_sel_rd <= !bank_sel_rd;
                tile_k <= k_wrap ? '0 : k_end[DIM_W-1:0];
                tile_n <= k_wrap ? (n_wrap ? '0 : n_end[DIM_W-1:0]) : tile_n;
                tile_m <= k_wrap && n_wrap ? (m_wrap ? '0 : m_end[DIM_W-1:0]) : tile_m;
            end
        end
    end
endmodule

// File: tb/tb_tile_scheduler.sv
// tb_tile_scheduler: directed vectors for tile_scheduler with hand-computed tile tables.
module tb_tile_scheduler;
    logic clk = 1'b0, rst = 1'b1;
    logic start_pulse = 1'b0, abort_pulse = 1'b0, irq_en = 1'b0;
    logic [31:0] cfg_M = '0, cfg_N = '0, cfg_K = '0, cfg_Tm = '0, cfg_Tn = '0, cfg_Tk = '0;
    logic tile_valid, tile_ready = 1'b1;
    logic [31:0] tile_m, tile_n, tile_k, tile_sm, tile_sn, tile_sk;
    logic tile_first_k, tile_last_k, core_tile_done = 1'b0;
    logic busy, done_tile_pulse, done_all_pulse, irq, cfg_err_pulse, bank_sel_rd;
    logic [31:0] tiles_issued;

    int n_tests = 0, n_fail = 0;
    logic bank_exp;
    logic [31:0] e_m[8], e_n[8], e_k[8], e_sm[8], e_sn[8], e_sk[8];
    logic e_fk[8], e_lk[8];

    tile_scheduler #(.DIM_W(32)) dut (
        .clk(clk), .rst(rst), .start_pulse(start_pulse), .abort_pulse(abort_pulse),
        .irq_en(irq_en), .cfg_M(cfg_M), .cfg_N(cfg_N), .cfg_K(cfg_K),
        .cfg_Tm(cfg_Tm), .cfg_Tn(cfg_Tn), .cfg_Tk(cfg_Tk),
        .tile_valid(tile_valid), .tile_ready(tile_ready),
        .tile_m(tile_m), .tile_n(tile_n), .tile_k(tile_k),
        .tile_sm(tile_sm), .tile_sn(tile_sn), .tile_sk(tile_sk),
        .tile_first_k(tile_first_k), .tile_last_k(tile_last_k),
        .core_tile_done(core_tile_done), .busy(busy),
        .done_tile_pulse(done_tile_pulse), .done_all_pulse(done_all_pulse),
        .irq(irq), .cfg_err_pulse(cfg_err_pulse), .bank_sel_rd(bank_sel_rd),
        .tiles_issued(tiles_issued)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [31:0] m, n, k, tm_, tn_, tk_);
        {cfg_M, cfg_N, cfg_K, cfg_Tm, cfg_Tn, cfg_Tk} = {m, n, k, tm_, tn_, tk_};
    endtask

    task automatic set_tile(input int i, input logic [31:0] m, n, k, sm, sn, sk, input logic fk, lk);
        e_m[i] = m; e_n[i] = n; e_k[i] = k;
        e_sm[i] = sm; e_sn[i] = sn; e_sk[i] = sk;
        e_fk[i] = fk; e_lk[i] = lk;
    endtask

    task automatic start_job();
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        bank_exp = 1'b0;
        check("start_busy", busy, 1);
        check("start_valid", tile_valid, 1);
        check("start_issued", tiles_issued, 0);
    endtask

    task automatic wait_valid();
        int c = 0;
        while (!tile_valid && c < 20) begin
            tick();
            c++;
        end
        check("valid_wait", tile_valid, 1);
    endtask

    // stall applies to the first tile of the range: tile_ready held low that many cycles
    task automatic run_tiles(input int lo, input int hi, input int total, input int stall);
        for (int i = lo; i <= hi; i++) begin
            wait_valid();
            check("tile_m", tile_m, e_m[i]);
            check("tile_n", tile_n, e_n[i]);
            check("tile_k", tile_k, e_k[i]);
            check("tile_sm", tile_sm, e_sm[i]);
            check("tile_sn", tile_sn, e_sn[i]);
            check("tile_sk", tile_sk, e_sk[i]);
            check("first_k", tile_first_k, e_fk[i]);
            check("last_k", tile_last_k, e_lk[i]);
            if (i == lo && stall > 0) begin
                tile_ready = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    tick();
                    check("stall_valid", tile_valid, 1);
                    check("stall_m", tile_m, e_m[i]);
                    check("stall_sm", tile_sm, e_sm[i]);
                    check("stall_lk", tile_last_k, e_lk[i]);
                    check("stall_issued", tiles_issued, i);
                end
                tile_ready = 1'b1;
            end
            tick();
            check("accept_valid", tile_valid, 0);
            check("issued", tiles_issued, i + 1);
            tick();
            core_tile_done = 1'b1;
            tick();
            core_tile_done = 1'b0;
            bank_exp = !bank_exp;
            check("done_tile", done_tile_pulse, e_lk[i]);
            check("done_all", done_all_pulse, i == total - 1);
            check("bank", bank_sel_rd, bank_exp);
        end
    endtask

    task automatic load_4x4();
        set_cfg(4, 4, 4, 2, 2, 2);
        for (int i = 0; i < 8; i++)
            set_tile(i, (i >> 2) * 2, ((i >> 1) & 1) * 2, (i & 1) * 2, 2, 2, 2, !(i & 1), i & 1);
    endtask

    initial begin
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_valid", tile_valid, 0);
        check("rst_issued", tiles_issued, 0);
        check("rst_bank", bank_sel_rd, 0);
        check("rst_first_k", tile_first_k, 0);
        check("rst_last_k", tile_last_k, 0);
        check("rst_sm", tile_sm, 0);
        rst = 1'b0;
        tick();

        // full 4x4x4 job, 2x2x2 tiles
        load_4x4();
        start_job();
        run_tiles(0, 7, 8, 0);
        check("j1_busy_done", busy, 1);
        check("j1_irq", irq, 0);
        check("j1_issued", tiles_issued, 8);
        tick();
        check("j1_busy_end", busy, 0);
        check("j1_done_all_end", done_all_pulse, 0);

        // edge-clipped m, n/k single tile, with a 3-cycle ready stall on tile 0
        set_cfg(5, 3, 3, 2, 4, 3);
        set_tile(0, 0, 0, 0, 2, 3, 3, 1, 1);
        set_tile(1, 2, 0, 0, 2, 3, 3, 1, 1);
        set_tile(2, 4, 0, 0, 1, 3, 3, 1, 1);
        start_job();
        run_tiles(0, 2, 3, 3);
        check("j2_issued", tiles_issued, 3);
        tick();
        check("j2_busy_end", busy, 0);

        // zero tile size rejected
        set_cfg(4, 4, 4, 2, 2, 0);
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        check("err_pulse", cfg_err_pulse, 1);
        check("err_busy", busy, 0);
        tick();
        check("err_pulse_end", cfg_err_pulse, 0);
        check("err_valid", tile_valid, 0);

        // zero dimension: straight to DONE
        set_cfg(4, 4, 0, 2, 2, 2);
        irq_en = 1'b1;
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        check("k0_done_all", done_all_pulse, 1);
        check("k0_irq", irq, 1);
        check("k0_busy", busy, 1);
        check("k0_issued", tiles_issued, 0);
        check("k0_valid", tile_valid, 0);
        tick();
        check("k0_busy_end", busy, 0);
        irq_en = 1'b0;

        // abort during WAIT of tile 3 coinciding with core_tile_done
        load_4x4();
        start_job();
        run_tiles(0, 1, 8, 0);
        wait_valid();
        tick();
        abort_pulse = 1'b1;
        core_tile_done = 1'b1;
        tick();
        abort_pulse = 1'b0;
        core_tile_done = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_valid", tile_valid, 0);
        check("ab_done_tile", done_tile_pulse, 0);
        check("ab_done_all", done_all_pulse, 0);
        check("ab_issued", tiles_issued, 3);
        check("ab_bank", bank_sel_rd, 0);
        tick();
        check("ab_done_tile2", done_tile_pulse, 0);
        start_job();
        run_tiles(0, 7, 8, 0);
        check("ab_rerun_issued", tiles_issued, 8);
        tick();

        // reset mid-job
        start_job();
        run_tiles(0, 0, 8, 0);
        wait_valid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_valid", tile_valid, 0);
        check("mr_busy", busy, 0);
        check("mr_issued", tiles_issued, 0);
        check("mr_bank", bank_sel_rd, 0);
        check("mr_tile_k", tile_k, 0);
        check("mr_sk", tile_sk, 0);
        check("mr_first_k", tile_first_k, 0);
        check("mr_last_k", tile_last_k, 0);
        tick();

        // bases near 2^32
        set_cfg(32'hFFFF_FFFF, 1, 1, 32'h8000_0000, 1, 1);
        set_tile(0, 0, 0, 0, 32'h8000_0000, 1, 1, 1, 1);
        set_tile(1, 32'h8000_0000, 0, 0, 32'h7FFF_FFFF, 1, 1, 1, 1);
        start_job();
        run_tiles(0, 1, 2, 0);
        check("big_issued", tiles_issued, 2);
        tick();
        check("big_busy_end", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tile_scheduler.md
Name: tile_scheduler

Overview:
- Sequences one GEMM job over the systolic core as a series of tile commands.
- At start it snapshots M/N/K and Tm/Tn/Tk from the CSR block, then walks the tile loop: m outer, n middle, k inner (output-stationary accumulation over k).
- Issues one tile at a time to the core over a valid/ready handshake and waits for the core's tile-complete pulse before issuing the next.
- Drives busy, per-output-tile done, job done, IRQ and read-bank ping-pong back to the CSR block.

Parameters:
- DIM_W, 32, width of the dimension, tile-size and index fields.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start_pulse  in  1  job start (W1P from CSR)
- abort_pulse  in  1  job abort (W1P from CSR)
- irq_en  in  1  interrupt enable
- cfg_M, cfg_N, cfg_K  in  DIM_W each  matrix dimensions
- cfg_Tm, cfg_Tn, cfg_Tk  in  DIM_W each  tile sizes
- tile_valid  out  1  tile command valid
- tile_ready  in  1  core accepts command
- tile_m, tile_n, tile_k  out  DIM_W each  tile base offsets
- tile_sm, tile_sn, tile_sk  out  DIM_W each  tile sizes, edge-clipped
- tile_first_k  out  1  first k tile (core clears accumulators)
- tile_last_k  out  1  last k tile (core writes back)
- core_tile_done  in  1  core finished the accepted tile (pulse)
- busy  out  1  job in progress
- done_tile_pulse  out  1  one output tile complete
- done_all_pulse  out  1  job complete
- irq  out  1  completion interrupt pulse
- cfg_err_pulse  out  1  start rejected: a tile size was zero
- bank_sel_rd  out  1  ping-pong read bank
- tiles_issued  out  32  accepted tile count for the current job

Behaviour:
- Reset (rst high at clk edge), and reset mid-operation: state=IDLE. All outputs 0: tile_valid, busy, all pulses, bank_sel_rd, tiles_issued, tile_* fields. Any in-flight tile is forgotten.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, start_pulse at cycle t, any of Tm/Tn/Tk == 0:
  - cfg_err_pulse=1 at t+1; stay IDLE; no tiles issued.
- IDLE, start_pulse at cycle t, any of M/N/K == 0 (tile sizes nonzero):
  - Go to DONE at t+1; no tiles issued.
- IDLE, start_pulse at cycle t, otherwise:
  - Snapshot all cfg_*; zero bases; tiles_issued=0; bank_sel_rd=0.
  - ISSUE at t+1 with tile_valid=1 and busy=1.
- start_pulse is ignored outside IDLE.
- ISSUE:
  - tile_valid=1; all tile_* fields held stable until tile_ready.
  - Size fields: tile_sm = min(Tm, M - tile_m); same rule for n and k.
  - tile_first_k = (tile_k == 0); tile_last_k = (tile_k + Tk >= K).
  - On tile_valid && tile_ready: tiles_issued += 1; go to WAIT, tile_valid=0 next cycle.
- WAIT:
  - core_tile_done at cycle u toggles bank_sel_rd.
  - If tile_last_k: done_tile_pulse at u+1.
  - Advance in k, then n, then m. A base wraps to 0 when base + T >= dim.
  - If this was the final tile (last k, last n, last m): DONE at u+1. Otherwise ISSUE at u+1 with the new tile.
  - core_tile_done in any state other than WAIT is ignored.
- DONE: lasts one cycle.
  - done_all_pulse=1 and irq=irq_en; busy still 1.
  - IDLE next cycle, where busy=0.
- Arithmetic: base + T is computed in DIM_W+1 bits, so no wrap-around for bases near 2^DIM_W. All bases satisfy base < dim.
- Abort: abort_pulse in any non-IDLE state forces IDLE next cycle.
  - tile_valid=0 and busy=0; no done, done_all or irq pulse.
  - tiles_issued and bank_sel_rd hold their values.
- Abort coinciding with start in IDLE: abort wins; the start is dropped.
- Abort coinciding with core_tile_done: abort wins; no done pulses.
- done_tile_pulse and done_all_pulse both assert in the same cycle for the final tile.
- Total tiles issued = ceil(M/Tm) * ceil(N/Tn) * ceil(K/Tk).

Test Plan:
- M=N=K=4, Tm=Tn=Tk=2; tile_ready tied 1; core_tile_done 2 cycles after accept -> 8 tiles in order (m,n,k): (0,0,0),(0,0,2),(0,2,0),(0,2,2),(2,0,0),(2,0,2),(2,2,0),(2,2,2). first_k/last_k alternate; 4 done_tile_pulse; 1 done_all_pulse; tiles_issued=8; bank_sel_rd ends 0; busy falls the cycle after DONE.
- M=5, N=3, K=3, Tm=2, Tn=4, Tk=3 -> tile_sm sequence 2,2,1; tile_sn=3; tile_sk=3; last_k=1 on every tile; 3 tiles.
- tile_ready held low 3 cycles -> tile_valid and all tile_* fields stable across those cycles; tiles_issued increments once.
- Tk=0 at start -> cfg_err_pulse 1 cycle, busy stays 0. K=0 -> done_all_pulse at t+1 (irq=1 if irq_en), tiles_issued=0.
- abort_pulse during WAIT of tile 3, then core_tile_done arrives -> IDLE next cycle, no done pulses, tiles_issued=3. A second start runs the full job from tile (0,0,0). Repeating with rst mid-job instead of abort gives all outputs 0 next cycle.
- M=0xFFFFFFFF, Tm=0x80000000, N=K=1, Tn=Tk=1 -> two tiles: tile_m=0 with tile_sm=0x80000000, then tile_m=0x80000000 with tile_sm=0x7FFFFFFF; then done.
